// File: rtl/serial_tx.sv
// Framed parallel-to-serial transmitter: start bit, WIDTH data bits LSB first, stop bit.
// Each bit lasts DIV clocks. Define PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic [WIDTH-1:0] D,
    input  logic             Load,
    output logic             S,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [CW-1:0]    cyc_reg, cyc_next;
    logic [BW-1:0]    bit_reg, bit_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic             s_reg, s_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             period_end;
`ifdef PARITY_EN
    logic             parity_reg, parity_next;
`endif

    assign period_end = (cyc_reg == CYC_LAST);

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        done_next  = 1'b0;
`ifdef PARITY_EN
        parity_next = parity_reg;
`endif
        if (state_reg == ST_IDLE) begin
            if (Load) begin
                state_next = ST_START;
                shift_next = D;
                cyc_next   = '0;
                bit_next   = '0;
`ifdef PARITY_EN
                parity_next = ^D;
`endif
            end
        end else begin
            cyc_next = period_end ? '0 : cyc_reg + 1'b1;
            if (period_end) begin
                case (state_reg)
                    ST_START: state_next = ST_DATA;
                    ST_DATA: begin
                        shift_next = shift_reg >> 1;
                        if (bit_reg == BIT_LAST) begin
                            bit_next = '0;
`ifdef PARITY_EN
                            state_next = ST_PARITY;
`else
                            state_next = ST_STOP;
`endif
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end
`ifdef PARITY_EN
                    ST_PARITY: state_next = ST_STOP;
`endif
                    ST_STOP: begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are derived from the next state so they register on the same edge as the transition.
    always_comb begin
        s_next = 1'b1;
        case (state_next)
            ST_START:  s_next = 1'b0;
            ST_DATA:   s_next = shift_next[0];
`ifdef PARITY_EN
            ST_PARITY: s_next = parity_reg;
`endif
            default:   s_next = 1'b1;
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_reg <= ST_IDLE;
            cyc_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            s_reg     <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            s_reg     <= s_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

    assign S    = s_reg;
    assign Busy = busy_reg;
    assign Done = done_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: a frame-level reference model checked every cycle on two instances
// (DIV=4 and DIV=1), plus directed frames with hand-computed bit sequences.
module tb_serial_tx;

`ifdef PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int W    = 8;
    localparam int F4   = (W + 2 + NPAR) * 4;
    localparam int F1   = (W + 2 + NPAR) * 1;

    logic       C = 1'b0;
    logic       R = 1'b0;
    logic [7:0] D = 8'h00;
    logic       Load = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic       load1 = 1'b0;
    logic       s4, busy4, done4, s1, busy1, done1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    serial_tx #(.WIDTH(8), .DIV(4)) u_dut4 (
        .C(C), .R(R), .D(D), .Load(Load), .S(s4), .Busy(busy4), .Done(done4)
    );
    serial_tx #(.WIDTH(8), .DIV(1)) u_dut1 (
        .C(C), .R(R), .D(d1), .Load(load1), .S(s1), .Busy(busy1), .Done(done1)
    );

    always #5 C = ~C;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: the line value at bit slot idx of a frame carrying word w.
    function automatic logic frame_bit(input logic [7:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= W) return w[idx-1];
        if (idx == W + 1 && NPAR == 1) return ^w;
        return 1'b1;
    endfunction

    bit         m_active [2];
    int         m_t      [2];
    logic [7:0] m_word   [2];
    bit         m_done   [2];
    int         m_div    [2] = '{4, 1};

    always @(posedge C or posedge R) begin
        for (int i = 0; i < 2; i++) begin
            if (R) begin
                m_active[i] = 1'b0;
                m_done[i]   = 1'b0;
            end else if (m_active[i]) begin
                m_t[i]++;
                if (m_t[i] == (W + 2 + NPAR) * m_div[i]) begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                end
            end else begin
                m_done[i] = 1'b0;
                if ((i == 0) ? Load : load1) begin
                    m_active[i] = 1'b1;
                    m_t[i]      = 0;
                    m_word[i]   = (i == 0) ? D : d1;
                end
            end
        end
    end

    always @(negedge C) begin
        if (chk_en) begin
            check("model_s4", {31'd0, s4},
                  {31'd0, m_active[0] ? frame_bit(m_word[0], m_t[0] / 4) : 1'b1});
            check("model_busy4", {31'd0, busy4}, {31'd0, m_active[0]});
            check("model_done4", {31'd0, done4}, {31'd0, m_done[0]});
            check("model_s1", {31'd0, s1},
                  {31'd0, m_active[1] ? frame_bit(m_word[1], m_t[1]) : 1'b1});
            check("model_busy1", {31'd0, busy1}, {31'd0, m_active[1]});
            check("model_done1", {31'd0, done1}, {31'd0, m_done[1]});
        end
    end

    // One frame on the DIV=4 instance; exp_sd[i] is the hand-computed line value of slot i (0..8).
    task automatic check_frame(input logic [7:0] w, input logic [8:0] exp_sd,
                               input logic exp_par, input int intf);
        @(negedge C);
        D = w;
        Load = 1'b1;
        @(posedge C);
        for (int j = 0; j <= F4 + 3; j++) begin
            @(negedge C);
            Load = (j == intf);
            if (j == intf) D = 8'hFF;
            if (j % 4 == 2 && j / 4 <= 8) check("frame_bit", {31'd0, s4}, {31'd0, exp_sd[j / 4]});
            if (j == F4 - 2) check("stop_bit", {31'd0, s4}, 32'd1);
`ifdef PARITY_EN
            if (j == 4 * (W + 1) + 2) check("parity_bit", {31'd0, s4}, {31'd0, exp_par});
`endif
            check("busy_window", {31'd0, busy4}, (j < F4) ? 32'd1 : 32'd0);
            check("done_pulse", {31'd0, done4}, (j == F4) ? 32'd1 : 32'd0);
        end
        if (exp_par === 1'bx) check("exp_par_known", 32'd0, 32'd1);
        $display("frame d=%h len=%0d checked", w, F4);
    endtask

    int dcount;

    initial begin
        #3 R = 1'b1;
        #1;
        check("rst_s", {31'd0, s4}, 32'd1);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_done", {31'd0, done4}, 32'd0);
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge C);
            check("rst_hold_s", {31'd0, s4}, 32'd1);
            check("rst_hold_busy", {31'd0, busy4}, 32'd0);
        end
        @(negedge C);
        #1 R = 1'b0;

        check_frame(8'hA5, 9'b101001010, 1'b0, -1);
        check_frame(8'h07, 9'b000001110, 1'b1, -1);
        check_frame(8'h3C, 9'b001111000, 1'b0, 10);

        // Back-to-back on the DIV=1 instance with Load held high.
        @(negedge C);
        d1 = 8'h01;
        load1 = 1'b1;
        @(posedge C);
        for (int j = 0; j <= 2 * F1 + 3; j++) begin
            @(negedge C);
            if (j == 0) d1 = 8'h80;
            if (j == 2 * F1 + 1) load1 = 1'b0;
            check("b2b_done", {31'd0, done1}, (j == F1 || j == 2 * F1 + 1) ? 32'd1 : 32'd0);
            if (j == 1) check("b2b_f1_bit0", {31'd0, s1}, 32'd1);
            if (j == F1 + 1) check("b2b_f2_start", {31'd0, s1}, 32'd0);
            if (j == F1 + 2) check("b2b_f2_bit0", {31'd0, s1}, 32'd0);
            if (j == F1 + 9) check("b2b_f2_bit7", {31'd0, s1}, 32'd1);
        end
        $display("back-to-back frames d=01,80 checked");

        // Reset in the middle of a frame.
        @(negedge C);
        D = 8'hA5;
        Load = 1'b1;
        @(posedge C);
        for (int j = 0; j < 17; j++) begin
            @(negedge C);
            Load = 1'b0;
        end
        @(negedge C);
        #1 R = 1'b1;
        #1;
        check("midrst_s", {31'd0, s4}, 32'd1);
        check("midrst_busy", {31'd0, busy4}, 32'd0);
        check("midrst_done", {31'd0, done4}, 32'd0);
        repeat (2) @(negedge C);
        #1 R = 1'b0;
        dcount = 0;
        repeat (F4 + 5) begin
            @(negedge C);
            if (done4) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        $display("mid-frame reset checked");
        check_frame(8'hA5, 9'b101001010, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out framed transmitter. It drives the single-bit serial line that the team's flip-flop capture chains and serial receivers sample. A parallel word is loaded with a one-cycle strobe, then shifted out LSB first, framed by a start bit and a stop bit, with each bit held for a programmable number of clocks. The block is fully synchronous to one clock and has an asynchronous active-high reset.

## Interface
- WIDTH, default 8: data bits per frame, minimum 1.
- DIV, default 4: clock cycles per serial bit, minimum 1.

- C, input, 1: clock. All state changes on the rising edge.
- R, input, 1: asynchronous, active-high reset.
- D, input, WIDTH: parallel word. Sampled only on an accepted Load.
- Load, input, 1: load strobe. Accepted only when Busy=0.
- S, output, 1: serial line. Idles high.
- Busy, output, 1: high while a frame is in progress.
- Done, output, 1: one-cycle pulse when a frame completes.

## Operation
- Reset values (R=1, effective immediately): S=1, Busy=0, Done=0, state IDLE, bit counter 0, cycle counter 0, shift register 0.
- States and transitions:
  - IDLE -> START on an accepted Load.
  - START -> DATA.
  - DATA -> PARITY if PARITY_EN is defined, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
  - Every state except IDLE lasts exactly DIV cycles.
- IDLE: S=1, Busy=0. If Load=1 at a rising edge, D is copied into the shift register and the state becomes START.
- START: S=0.
- DATA:
  - S = shift-register bit 0.
  - At the end of each DIV-cycle bit, shift right by one.
  - After WIDTH bits (bit counter reaches WIDTH-1 at end of period), advance to the next state.
- STOP: S=1. At the end of the period: go to IDLE, assert Done for one cycle, drop Busy.
- Load while Busy=1 is ignored. D is not sampled and the frame is unaffected.
- Changes on D after acceptance have no effect on the frame in flight.
- Counters:
  - Cycle counter width is clog2(DIV), with a minimum of 1 bit. It wraps 0..DIV-1.
  - Bit counter width is clog2(WIDTH), with a minimum of 1 bit.
  - DIV=1 is legal: one cycle per bit.
- Reset mid-frame: the frame is abandoned, S returns to 1 asynchronously, and no Done is produced.

## Timing
- All outputs are registered. S, Busy and Done never change combinationally from D or Load.
- Load accepted at edge k: Busy=1 and S=0 from edge k onward.
- Frame length F is measured from edge k to the edge where Busy falls:
  - (WIDTH+2)*DIV cycles without parity.
  - (WIDTH+3)*DIV cycles with parity.
- Done is high for exactly one cycle, from edge k+F. Busy=0 in that same cycle.
- Back-to-back frames: Load=1 in the Done cycle is accepted at edge k+F+1. The line goes from stop bit straight to the next start bit with a 1-cycle idle gap.
- Load held high continuously produces frames every F+1 cycles.

## Configuration
- PARITY_EN defined: a PARITY state is inserted between DATA and STOP.
  - S = XOR of the WIDTH loaded bits (even parity), held DIV cycles.
  - Parity is computed from the loaded word at acceptance.
- PARITY_EN undefined: no PARITY state and no parity logic. Frame length is (WIDTH+2)*DIV.

## Test plan
- Reset: assert R mid-cycle with no clock edge -> S=1, Busy=0, Done=0 immediately; hold 3 cycles, outputs unchanged.
- Basic frame (WIDTH=8, DIV=4, no parity): D=8'hA5, Load pulse at edge 0 -> S bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Busy=1 for cycles 0..39; Done=1 only in cycle 40.
- Parity (PARITY_EN, same params): D=8'hA5 -> parity bit 0, frame 44 cycles; D=8'h07 -> parity bit 1.
- Load while busy: D=8'h3C loaded, then D=8'hFF with Load=1 at cycle 10 -> serial data bits still 0,0,1,1,1,1,0,0; no second frame starts.
- Back-to-back (DIV=1): Load held high with D=8'h01 then 8'h80 -> frames start 11 cycles apart; Done pulses at cycles 10 and 21.
- Reset mid-frame: R asserted at cycle 17 of an 8'hA5 frame -> S=1 at once, no Done; the next Load after R deasserts yields a complete correct frame.
